arb_agent: RTL

Requesting-agent side of the 4-port round-robin bus arbiter: one instance per arbiter port. Queues local burst-write commands, raises `request`, waits for `grant`, drives the burst on the shared bus, then pulses `end_transaction` so the arbiter can release the bus. Also flags grant timeouts and grant loss during a burst.

---
 rtl/arb_agent_pkg.sv | 20 ++
 rtl/arb_agent_if.sv | 28 ++
 rtl/sync_fifo.sv | 42 ++++
 rtl/arb_agent.sv | 132 +++++++++++++
 4 files changed

// File: rtl/arb_agent_pkg.sv
// Shared constants for the round-robin arbiter agent: state encodings,
// port count and small state-decoding helpers.
package arb_agent_pkg;

  localparam int ARB_PORTS = 4;

  localparam logic [1:0] AGT_IDLE = 2'd0;
  localparam logic [1:0] AGT_REQ  = 2'd1;
  localparam logic [1:0] AGT_XFER = 2'd2;
  localparam logic [1:0] AGT_END  = 2'd3;

  function automatic logic agt_requesting(input logic [1:0] st);
    return (st == AGT_REQ) || (st == AGT_XFER);
  endfunction

  function automatic logic agt_busy(input logic [1:0] st);
    return st != AGT_IDLE;
  endfunction

endpackage

// File: rtl/arb_agent_if.sv
// Arbiter handshake plus shared-bus beat signals seen by one agent.
// master = agent side, slave = arbiter/bus/local-source side.
interface arb_agent_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) ();

  logic              request;
  logic              grant;
  logic              end_transaction;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic [DATA_W-1:0] data_in;
  logic              data_pop;

  modport master (
    output request, end_transaction, bus_valid, bus_addr, bus_data, data_pop,
    input  grant, bus_ready, data_in
  );

  modport slave (
    input  request, end_transaction, bus_valid, bus_addr, bus_data, data_pop,
    output grant, bus_ready, data_in
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO holding queued burst commands; dout is the
// current head whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full)  wr_q <= wr_q + 1'b1;
      if (pop  && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[PW-1:0]] <= din;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dout  = mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/arb_agent.sv
// Requesting agent for one arbiter port: queues burst commands, requests
// the bus, drives the burst once granted and signals end of transaction.
module arb_agent
  import arb_agent_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int LEN_W       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              gnt_timeout,
  output logic              xfer_abort,
  output logic              busy,
  arb_agent_if.master       bus
);

  localparam int CMD_W = ADDR_W + LEN_W;
  localparam int WC_W  = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(GNT_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              tout_q, tout_d;
  logic              abort_q, abort_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CMD_W-1:0]  fifo_dout;
  logic [DATA_W-1:0] beat_data;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == AGT_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cmd_addr, cmd_len}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Losing grant mid-burst outranks a beat accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    tout_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      AGT_IDLE: begin
        if (!fifo_empty) begin
          state_d = AGT_REQ;
          addr_d  = fifo_dout[CMD_W-1:LEN_W];
          beats_d = fifo_dout[LEN_W-1:0];
          wait_d  = '0;
        end
      end
      AGT_REQ: begin
        if (bus.grant) begin
          state_d = AGT_XFER;
        end else if (wait_q == WAIT_LAST) begin
          tout_d = 1'b1;
          wait_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      AGT_XFER: begin
        if (!bus.grant) begin
          abort_d = 1'b1;
          state_d = AGT_IDLE;
        end else if (bus.bus_ready) begin
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          if (beats_q == '0) state_d = AGT_END;
        end
      end
      AGT_END:  state_d = AGT_IDLE;
      default:  state_d = AGT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= AGT_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      wait_q  <= '0;
      tout_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      tout_q  <= tout_d;
      abort_q <= abort_d;
    end
  end

  assign beat_data           = bus.data_in;
  assign bus.bus_data        = beat_data;
  assign bus.request         = agt_requesting(state_q);
  assign bus.bus_valid       = (state_q == AGT_XFER);
  assign bus.end_transaction = (state_q == AGT_END);
  assign bus.bus_addr        = addr_q;
  assign bus.data_pop        = bus.bus_valid && bus.bus_ready;

  assign busy        = agt_busy(state_q);
  assign gnt_timeout = tout_q;
  assign xfer_abort  = abort_q;

endmodule
